// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_t    - loader FSM states
//   HDR_BYTES  - bytes in the word-count header
//   WORD_BYTES - bytes per instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus.
//   InData/InValid/InReady - valid/ready byte stream into the loader
//   MemAddr/MemData/MemWE  - word write port toward instruction memory
// master: the loader side (sinks the stream, drives the write bus).
// slave:  the environment side (sources the stream, observes/accepts writes).
interface imem_loader_if;

  logic [7:0]  InData;
  logic        InValid;
  logic        InReady;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        MemWE;

  modport master (
    input  InData, InValid,
    output InReady, MemAddr, MemData, MemWE
  );

  modport slave (
    output InData, InValid,
    input  InReady, MemAddr, MemData, MemWE
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: 8-to-32 MSB-first shift register with a byte counter.
//   clk, rst - clock, synchronous active-high reset
//   clr      - synchronous clear of counter and partial word
//   en       - shift din in this cycle
//   din      - incoming byte
//   word     - word as it will look once din is shifted in (combinational)
//   full     - high in the cycle the last byte of a word is being shifted in
// word/full are look-ahead so the owner can act on a complete word on the
// same edge that accepts its final byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        full
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] cnt;
  logic [31:0]   sr;

  assign word = {sr[23:0], din};
  assign full = en && (cnt == CW'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      sr  <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: serial program loader for the instruction memory.
// Takes a byte stream (4-byte big-endian word count N, then N big-endian
// words) and writes each word to BASE + 4*k, holding the CPU until done.
//   Clk, Reset - clock, synchronous active-high reset
//   Start      - begin a load (honored in IDLE, DONE, ERR)
//   bus        - stream handshake in, memory write bus out
//   CpuHold    - holds fetch PC in reset; low only in DONE
//   Done, Err  - load complete / header count exceeds capacity
//   WordCnt    - words written in the current load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  imem_loader_if.master     bus,
  output logic              CpuHold,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W:0]   WordCnt
);

  // Capacity in words; N equal to this is still legal.
  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  state_t          state, state_nxt;
  logic [31:0]     n_words;
  logic [ADDR_W:0] word_cnt;
  logic [31:0]     mem_addr, mem_data;
  logic            mem_we;
  logic            in_ready, load_go, accept;
  logic [31:0]     pk_word;
  logic            pk_full;

  assign accept = bus.InValid && in_ready;

  // One packer serves both header and payload; its counter wraps to zero
  // after the 4th header byte, so payload alignment comes for free.
  byte_packer u_pack (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (load_go),
    .en   (accept),
    .din  (bus.InData),
    .word (pk_word),
    .full (pk_full)
  );

  always_comb begin
    state_nxt = state;
    load_go   = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (Start) begin
          load_go   = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        in_ready = 1'b1;
        if (pk_full) begin
          if (pk_word == 32'd0)              state_nxt = DONE;
          else if ({1'b0, pk_word} > CAP)    state_nxt = ERR;
          else                               state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        // word_cnt already counts the word on the bus during MemWE
        if (mem_we && (32'(word_cnt) == n_words)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      n_words  <= '0;
      word_cnt <= '0;
      mem_we   <= 1'b0;
      mem_addr <= BASE;
      mem_data <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;
      if (load_go) begin
        word_cnt <= '0;
        mem_addr <= BASE;
      end
      if (state == HDR && pk_full) n_words <= pk_word;
      if (state == DATA && pk_full) begin
        mem_we   <= 1'b1;
        mem_data <= pk_word;
        mem_addr <= BASE + (32'(word_cnt) << 2);
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  assign bus.InReady = in_ready;
  assign bus.MemAddr = mem_addr;
  assign bus.MemData = mem_data;
  assign bus.MemWE   = mem_we;
  assign CpuHold     = (state != DONE);
  assign Done        = (state == DONE);
  assign Err         = (state == ERR);
  assign WordCnt     = word_cnt;

endmodule
